// File: rtl/memory_arbiter.sv
// Two-requester round-robin front end for the single-port NVM array, with a
// hardware sector-erase sequencer. Optional write lock: MEMORY_ARBITER_WRITE_LOCK_EN.
module memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_0,
    output logic                  req_ready_1,
    input  logic                  req_write_0,
    input  logic                  req_write_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  rsp_valid_0,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_rdata_0,
    output logic [DATA_WIDTH-1:0] rsp_rdata_1,
`ifdef MEMORY_ARBITER_WRITE_LOCK_EN
    input  logic                  write_lock,
    output logic                  rsp_err_0,
    output logic                  rsp_err_1,
`endif
    input  logic                  erase_start,
    output logic                  erase_busy,
    output logic                  erase_done,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);
    typedef enum logic {IDLE, ERASE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] counter;
    logic                  last_grant;
    logic                  grant_0, grant_1;
    logic                  erase_go;
    logic                  lock;

`ifdef MEMORY_ARBITER_WRITE_LOCK_EN
    assign lock = write_lock;
`else
    assign lock = 1'b0;
`endif

    // Round robin: on contention the requester that did not win last goes.
    assign grant_0  = req_valid_0 & (~req_valid_1 | last_grant);
    assign grant_1  = req_valid_1 & (~req_valid_0 | ~last_grant);
    assign erase_go = erase_start & ~lock;
    assign erase_busy = (state == ERASE);

    always_comb begin
        next_state       = state;
        req_ready_0      = 1'b0;
        req_ready_1      = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_data_in      = '0;
        // Reset is folded in so the array sees no write strobe while held.
        if (reset) begin
            case (state)
                IDLE: begin
                    if (erase_go) begin
                        next_state = ERASE;
                    end else if (grant_0) begin
                        req_ready_0      = 1'b1;
                        mem_address      = req_addr_0;
                        mem_data_in      = req_wdata_0;
                        mem_write_enable = req_write_0 & ~lock;
                    end else if (grant_1) begin
                        req_ready_1      = 1'b1;
                        mem_address      = req_addr_1;
                        mem_data_in      = req_wdata_1;
                        mem_write_enable = req_write_1 & ~lock;
                    end
                end
                ERASE: begin
                    mem_write_enable = 1'b1;
                    mem_address      = counter;
                    if (counter == LAST_ADDR) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    logic xfer_0, xfer_1;
    assign xfer_0 = req_valid_0 & req_ready_0;
    assign xfer_1 = req_valid_1 & req_ready_1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            last_grant  <= 1'b1;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_rdata_0 <= '0;
            rsp_rdata_1 <= '0;
            erase_done  <= 1'b0;
        end else begin
            state       <= next_state;
            rsp_valid_0 <= xfer_0;
            rsp_valid_1 <= xfer_1;
            erase_done  <= (state == ERASE) && (counter == LAST_ADDR);
            if (state == ERASE)  counter <= counter + 1'b1;
            else if (erase_go)   counter <= '0;
            if (xfer_0) begin
                rsp_rdata_0 <= mem_data_out;
                last_grant  <= 1'b0;
            end
            if (xfer_1) begin
                rsp_rdata_1 <= mem_data_out;
                last_grant  <= 1'b1;
            end
        end
    end

`ifdef MEMORY_ARBITER_WRITE_LOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err_0 <= 1'b0;
            rsp_err_1 <= 1'b0;
        end else begin
            rsp_err_0 <= xfer_0 & req_write_0 & write_lock;
            rsp_err_1 <= xfer_1 & req_write_1 & write_lock;
        end
    end
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a local model of the NVM array.
module tb_memory_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic        req_write_0, req_write_1;
    logic [5:0]  req_addr_0, req_addr_1;
    logic [31:0] req_wdata_0, req_wdata_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_rdata_0, rsp_rdata_1;
    logic        erase_start, erase_busy, erase_done;
    logic        mem_write_enable;
    logic [5:0]  mem_address;
    logic [31:0] mem_data_in, mem_data_out;
`ifdef MEMORY_ARBITER_WRITE_LOCK_EN
    logic        write_lock, rsp_err_0, rsp_err_1;
`endif

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [64];
    logic        pl_en = 1'b0;

    function automatic logic [31:0] pat(int i);
        if (i == 5)  return 32'hDEADBEEF;
        if (i == 63) return 32'h0;
        return 32'hA500_0000 + i + 1;
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
        end else if (mem_write_enable) begin
            mem[mem_address] <= mem_data_in;
        end
    end
    assign mem_data_out = mem[mem_address];

    memory_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_write_0(req_write_0), .req_write_1(req_write_1),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
        .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
`ifdef MEMORY_ARBITER_WRITE_LOCK_EN
        .write_lock(write_lock), .rsp_err_0(rsp_err_0), .rsp_err_1(rsp_err_1),
`endif
        .erase_start(erase_start), .erase_busy(erase_busy), .erase_done(erase_done),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        pl_en = 1'b1;
        cyc();
        pl_en = 1'b0;
    endtask

    task automatic idle_inputs();
        req_valid_0 = 0; req_valid_1 = 0; req_write_0 = 0; req_write_1 = 0;
        req_addr_0 = 0; req_addr_1 = 0; req_wdata_0 = 0; req_wdata_1 = 0;
        erase_start = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        req_valid_0 = 1'b1; req_write_0 = 1'b1; req_addr_0 = 6'd9;
        repeat (2) cyc();
        total++; if (req_ready_0 !== 1'b0) $display("FAIL reset_ready0 got %b want 0", req_ready_0); else passed++;
        total++; if (mem_write_enable !== 1'b0 || mem_address !== 6'd0)
            $display("FAIL reset_mem got we=%b addr=%0d want 0/0", mem_write_enable, mem_address); else passed++;
        total++; if (rsp_valid_0 !== 1'b0 || rsp_rdata_0 !== 32'h0 || rsp_rdata_1 !== 32'h0)
            $display("FAIL reset_rsp got v=%b d0=%h d1=%h want 0", rsp_valid_0, rsp_rdata_0, rsp_rdata_1); else passed++;
        total++; if (erase_busy !== 1'b0 || erase_done !== 1'b0)
            $display("FAIL reset_erase got busy=%b done=%b want 0/0", erase_busy, erase_done); else passed++;
        idle_inputs();
        reset = 1'b1;
        preload();
        total++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0 || mem_write_enable !== 1'b0)
            $display("FAIL idle_no_ready got r0=%b r1=%b we=%b want 0", req_ready_0, req_ready_1, mem_write_enable); else passed++;
    endtask

    task automatic test_single_read();
        req_valid_0 = 1'b1; req_addr_0 = 6'd5;
        #1;
        total++; if (req_ready_0 !== 1'b1 || mem_address !== 6'd5 || mem_write_enable !== 1'b0)
            $display("FAIL read_grant got r0=%b addr=%0d we=%b want 1/5/0", req_ready_0, mem_address, mem_write_enable); else passed++;
        cyc();
        req_valid_0 = 1'b0;
        total++; if (rsp_valid_0 !== 1'b1 || rsp_rdata_0 !== 32'hDEADBEEF)
            $display("FAIL read_rsp got v=%b d=%h want 1/deadbeef", rsp_valid_0, rsp_rdata_0); else passed++;
        cyc();
        total++; if (rsp_valid_0 !== 1'b0 || rsp_rdata_0 !== 32'hDEADBEEF)
            $display("FAIL read_hold got v=%b d=%h want 0/deadbeef", rsp_valid_0, rsp_rdata_0); else passed++;
    endtask

    task automatic test_write_read();
        req_valid_1 = 1'b1; req_write_1 = 1'b1; req_addr_1 = 6'd63; req_wdata_1 = 32'h12345678;
        #1;
        total++; if (req_ready_1 !== 1'b1 || mem_write_enable !== 1'b1 || mem_data_in !== 32'h12345678)
            $display("FAIL write_grant got r1=%b we=%b din=%h want 1/1/12345678", req_ready_1, mem_write_enable, mem_data_in); else passed++;
        cyc();
        req_write_1 = 1'b0;
        total++; if (rsp_valid_1 !== 1'b1 || rsp_rdata_1 !== 32'h0 || mem[63] !== 32'h12345678)
            $display("FAIL write_rsp got v=%b d=%h mem=%h want 1/0/12345678", rsp_valid_1, rsp_rdata_1, mem[63]); else passed++;
        cyc();
        req_valid_1 = 1'b0;
        total++; if (rsp_valid_1 !== 1'b1 || rsp_rdata_1 !== 32'h12345678)
            $display("FAIL readback got v=%b d=%h want 1/12345678", rsp_valid_1, rsp_rdata_1); else passed++;
        cyc();
    endtask

    task automatic test_contention();
        int n0 = 0, n1 = 0;
        logic g0;
        req_valid_0 = 1'b1; req_addr_0 = 6'd1;
        req_valid_1 = 1'b1; req_addr_1 = 6'd2;
        for (int k = 0; k < 4; k++) begin
            g0 = (k % 2 == 0);
            #1;
            total++; if (req_ready_0 !== g0 || req_ready_1 !== !g0)
                $display("FAIL contend_grant%0d got r0=%b r1=%b want %b/%b", k, req_ready_0, req_ready_1, g0, !g0); else passed++;
            cyc();
            if (rsp_valid_0) n0++;
            if (rsp_valid_1) n1++;
            if (g0) begin
                total++; if (rsp_rdata_0 !== pat(1)) $display("FAIL contend_d0 got %h want %h", rsp_rdata_0, pat(1)); else passed++;
            end else begin
                total++; if (rsp_rdata_1 !== pat(2)) $display("FAIL contend_d1 got %h want %h", rsp_rdata_1, pat(2)); else passed++;
            end
        end
        idle_inputs();
        cyc();
        total++; if (n0 !== 2 || n1 !== 2) $display("FAIL contend_pulses got %0d/%0d want 2/2", n0, n1); else passed++;
    endtask

    task automatic test_erase();
        int bad = 0;
        req_valid_0 = 1'b1; req_addr_0 = 6'd7; erase_start = 1'b1;
        #1;
        total++; if (req_ready_0 !== 1'b0) $display("FAIL erase_prio got r0=%b want 0", req_ready_0); else passed++;
        cyc();
        erase_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (erase_busy !== 1'b1 || req_ready_0 !== 1'b0 || erase_done !== 1'b0 ||
                mem_address !== 6'(i) || mem_write_enable !== 1'b1 || mem_data_in !== 32'h0) bad++;
            cyc();
        end
        total++; if (bad !== 0) $display("FAIL erase_walk got %0d bad cycles want 0", bad); else passed++;
        total++; if (erase_busy !== 1'b0 || erase_done !== 1'b1 || req_ready_0 !== 1'b1)
            $display("FAIL erase_end got busy=%b done=%b r0=%b want 0/1/1", erase_busy, erase_done, req_ready_0); else passed++;
        cyc();
        req_valid_0 = 1'b0;
        total++; if (erase_done !== 1'b0 || rsp_valid_0 !== 1'b1 || rsp_rdata_0 !== 32'h0)
            $display("FAIL erase_after got done=%b v=%b d=%h want 0/1/0", erase_done, rsp_valid_0, rsp_rdata_0); else passed++;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 32'h0) bad++;
        total++; if (bad !== 0) $display("FAIL erase_zero got %0d nonzero words want 0", bad); else passed++;
    endtask

    task automatic test_reset_mid_erase();
        int bad = 0, done_seen = 0;
        preload();
        erase_start = 1'b1;
        cyc();
        erase_start = 1'b0;
        repeat (10) cyc();
        total++; if (mem_address !== 6'd10) $display("FAIL abort_pos got %0d want 10", mem_address); else passed++;
        reset = 1'b0;
        #1;
        total++; if (erase_busy !== 1'b0 || mem_write_enable !== 1'b0)
            $display("FAIL abort_now got busy=%b we=%b want 0/0", erase_busy, mem_write_enable); else passed++;
        repeat (2) begin cyc(); if (erase_done) done_seen++; end
        reset = 1'b1;
        repeat (3) begin cyc(); if (erase_done) done_seen++; end
        total++; if (done_seen !== 0) $display("FAIL abort_done got %0d pulses want 0", done_seen); else passed++;
        for (int i = 0; i < 64; i++) if (mem[i] !== ((i < 10) ? 32'h0 : pat(i))) bad++;
        total++; if (bad !== 0) $display("FAIL abort_partial got %0d wrong words want 0", bad); else passed++;
    endtask

`ifdef MEMORY_ARBITER_WRITE_LOCK_EN
    task automatic test_write_lock();
        preload();
        write_lock = 1'b1;
        req_valid_0 = 1'b1; req_write_0 = 1'b1; req_addr_0 = 6'd3; req_wdata_0 = 32'hFFFFFFFF;
        #1;
        total++; if (req_ready_0 !== 1'b1 || mem_write_enable !== 1'b0)
            $display("FAIL lock_grant got r0=%b we=%b want 1/0", req_ready_0, mem_write_enable); else passed++;
        cyc();
        req_write_0 = 1'b0;
        total++; if (rsp_err_0 !== 1'b1 || rsp_rdata_0 !== pat(3) || mem[3] !== pat(3))
            $display("FAIL lock_err got err=%b d=%h mem=%h want 1/%h/%h", rsp_err_0, rsp_rdata_0, mem[3], pat(3), pat(3)); else passed++;
        cyc();
        req_valid_0 = 1'b0;
        total++; if (rsp_err_0 !== 1'b0 || rsp_valid_0 !== 1'b1)
            $display("FAIL lock_read got err=%b v=%b want 0/1", rsp_err_0, rsp_valid_0); else passed++;
        erase_start = 1'b1;
        cyc();
        erase_start = 1'b0;
        total++; if (erase_busy !== 1'b0) $display("FAIL lock_erase got busy=%b want 0", erase_busy); else passed++;
        write_lock = 1'b0;
        cyc();
    endtask
`endif

    initial begin
`ifdef MEMORY_ARBITER_WRITE_LOCK_EN
        write_lock = 1'b0;
`endif
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_erase();
        test_reset_mid_erase();
`ifdef MEMORY_ARBITER_WRITE_LOCK_EN
        test_write_lock();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
